// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART state encoding and frame constants
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_BREAK
    } uart_state_e;

    localparam int   DEFAULT_CLKS_PER_BIT = 434;
    localparam logic START_BIT            = 1'b0;
    localparam logic STOP_BIT             = 1'b1;

endpackage

// File: rtl/uart_sync2.sv
// rtl/uart_sync2.sv - two-flop synchronizer with selectable reset value
module uart_sync2 #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver, mid-bit sampling with break detection
module uart_rx
    import uart_pkg::*;
#(
    parameter int DATA         = 8,
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            rx_in,
    output logic [DATA-1:0] rx_data,
    output logic            rx_valid,
    output logic            rx_busy,
    output logic            frame_err
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = (DATA > 1) ? $clog2(DATA) : 1;
    localparam logic [CW-1:0] HALF_CNT = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA - 1);

    logic            rxs;
    uart_state_e     state_q;
    logic [CW-1:0]   cnt_q;
    logic [BW-1:0]   bit_q;
    logic [DATA-1:0] shift_q;
    logic [DATA-1:0] rx_data_q;
    logic            rx_valid_q;
    logic            rx_busy_q;
    logic            frame_err_q;

    uart_sync2 #(.RESET_VAL(1'b1)) u_sync (
        .clk   (clk),
        .reset (reset),
        .d_i   (rx_in),
        .q_o   (rxs)
    );

    // rx_busy_q is written alongside every state change so it tracks the next state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            bit_q       <= '0;
            shift_q     <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            rx_busy_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    cnt_q <= '0;
                    if (rxs == START_BIT) begin
                        state_q   <= ST_START;
                        rx_busy_q <= 1'b1;
                    end
                end
                ST_START: begin
                    if (cnt_q == HALF_CNT) begin
                        cnt_q <= '0;
                        if (rxs == START_BIT) begin
                            state_q <= ST_DATA;
                            bit_q   <= '0;
                        end else begin
                            state_q   <= ST_IDLE;
                            rx_busy_q <= 1'b0;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (cnt_q == FULL_CNT) begin
                        cnt_q   <= '0;
                        shift_q <= {rxs, shift_q[DATA-1:1]};
                        if (bit_q == LAST_BIT) begin
                            state_q <= ST_STOP;
                        end else begin
                            bit_q <= bit_q + 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_STOP: begin
                    if (cnt_q == FULL_CNT) begin
                        cnt_q <= '0;
                        if (rxs == STOP_BIT) begin
                            rx_data_q  <= shift_q;
                            rx_valid_q <= 1'b1;
                            state_q    <= ST_IDLE;
                            rx_busy_q  <= 1'b0;
                        end else begin
                            frame_err_q <= 1'b1;
                            state_q     <= ST_BREAK;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_BREAK: begin
                    cnt_q <= '0;
                    if (rxs == STOP_BIT) begin
                        state_q   <= ST_IDLE;
                        rx_busy_q <= 1'b0;
                    end
                end
                default: begin
                    state_q   <= ST_IDLE;
                    cnt_q     <= '0;
                    rx_busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign rx_busy   = rx_busy_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - randomized self-checking bench for uart_rx against an event-queue model
`timescale 1ns/1ps
module tb_uart_rx;

    localparam int  CPB = 434;
    localparam longint LAT = 2 + CPB / 2 + 9 * CPB + 1;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       rx_in = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_busy;
    logic       frame_err;

    uart_rx #(.DATA(8), .CLKS_PER_BIT(CPB)) dut (
        .clk       (clk),
        .reset     (reset),
        .rx_in     (rx_in),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_busy   (rx_busy),
        .frame_err (frame_err)
    );

    always #10 clk = ~clk;

    typedef struct {
        bit         is_err;
        logic [7:0] data;
        longint     due;
    } exp_t;

    exp_t       expq[$];
    logic [7:0] model_data = 8'h00;
    longint     cyc = 0;
    longint     last_valid_cyc = 0;
    int         n_cmp = 0;
    int         n_bad = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input longint act, input longint exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp_v, exp_v);
        end
    endtask

    task automatic chk_range(input string nm, input longint act, input longint lo, input longint hi);
        n_cmp++;
        if (act < lo || act > hi) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d..%0d", nm, act, lo, hi);
        end
    endtask

    // Model: every frame launched by the bench schedules one outcome at fall + LAT.
    always @(negedge clk) begin
        if (!reset) begin
            expq.delete();
            model_data = 8'h00;
        end else begin
            if (rx_valid || frame_err) begin
                chk("valid_err_exclusive", longint'(rx_valid & frame_err), 0);
                if (expq.size() == 0) begin
                    chk("unexpected_strobe", 1, 0);
                end else begin
                    exp_t e;
                    e = expq.pop_front();
                    chk("strobe_kind_err", longint'(frame_err), longint'(e.is_err));
                    chk_range("strobe_time", cyc, e.due - 1, e.due + 1);
                    if (!e.is_err) begin
                        chk("rx_data_on_valid", rx_data, e.data);
                        chk("busy_low_at_valid", longint'(rx_busy), 0);
                        model_data = e.data;
                        last_valid_cyc = cyc;
                    end
                end
            end
            if (rx_data !== model_data) chk("rx_data_hold", rx_data, model_data);
            if (expq.size() > 0 && cyc > expq[0].due + 1) begin
                chk("missing_strobe", 0, 1);
                void'(expq.pop_front());
            end
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive_bit(input logic b);
        rx_in = b;
        wait_cycles(CPB);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_b, output longint fall);
        exp_t e;
        fall     = cyc;
        e.is_err = (stop_b == 1'b0);
        e.data   = d;
        e.due    = fall + LAT;
        expq.push_back(e);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        drive_bit(stop_b);
    endtask

    initial begin
        longint     f;
        int         busy_cnt;
        logic [7:0] burst [4];
        logic [7:0] d;
        burst = '{8'hD3, 8'hA5, 8'h3C, 8'h55};

        // Reset state
        wait_cycles(3);
        chk("reset_rx_data", rx_data, 0);
        chk("reset_rx_valid", longint'(rx_valid), 0);
        chk("reset_rx_busy", longint'(rx_busy), 0);
        chk("reset_frame_err", longint'(frame_err), 0);
        reset = 1'b1;
        wait_cycles(5);

        // Single byte
        send_frame(8'hD3, 1'b1, f);
        chk("single_rx_data", rx_data, 8'hD3);
        chk("single_busy_after", longint'(rx_busy), 0);

        // Back-to-back burst with zero idle
        for (int i = 0; i < 4; i++) send_frame(burst[i], 1'b1, f);
        wait_cycles(5);
        chk("burst_last_data", rx_data, 8'h55);
        chk("burst_queue_drained", expq.size(), 0);

        // Glitch start shorter than half a bit
        busy_cnt = 0;
        rx_in = 1'b0;
        for (int i = 0; i < 100; i++) begin
            wait_cycles(1);
            if (rx_busy) busy_cnt++;
        end
        rx_in = 1'b1;
        for (int i = 0; i < 400; i++) begin
            wait_cycles(1);
            if (rx_busy) busy_cnt++;
        end
        chk_range("glitch_busy_cycles", busy_cnt, 1, 220);
        chk("glitch_busy_end", longint'(rx_busy), 0);

        // Framing error followed by a held-low break
        send_frame(8'h55, 1'b0, f);
        wait_cycles(1000);
        chk("break_busy_held", longint'(rx_busy), 1);
        chk("break_data_kept", rx_data, 8'h55);
        rx_in = 1'b1;
        wait_cycles(5);
        chk("break_released", longint'(rx_busy), 0);
        send_frame(8'hA5, 1'b1, f);
        chk("after_break_data", rx_data, 8'hA5);

        // Reset during bit 4 of 0x3C
        d = 8'h3C;
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(d[i]);
        rx_in = d[4];
        wait_cycles(CPB / 2);
        chk("pre_reset_busy", longint'(rx_busy), 1);
        reset = 1'b0;
        #1;
        chk("midreset_rx_data", rx_data, 0);
        chk("midreset_rx_busy", longint'(rx_busy), 0);
        chk("midreset_rx_valid", longint'(rx_valid), 0);
        chk("midreset_frame_err", longint'(frame_err), 0);
        rx_in = 1'b1;
        wait_cycles(4);
        reset = 1'b1;
        wait_cycles(2000);
        chk("post_reset_idle", longint'(rx_busy), 0);
        send_frame(8'h3C, 1'b1, f);
        chk("post_reset_data", rx_data, 8'h3C);

        // Latency from falling edge to strobe
        send_frame(8'hFF, 1'b1, f);
        chk_range("latency_ff", last_valid_cyc - f, 4125, 4127);

        // Random bytes with random idle gaps
        for (int i = 0; i < 5; i++) begin
            d = 8'($urandom_range(0, 255));
            wait_cycles($urandom_range(0, 40));
            send_frame(d, 1'b1, f);
        end

        for (int i = 0; i < 6000 && expq.size() > 0; i++) wait_cycles(1);
        chk("final_queue_empty", expq.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #(20 * 100000);
        $display("FAIL watchdog: simulation exceeded cycle budget");
        $fatal(1);
    end

endmodule
